// File: rtl/fp21_nearest_hit.sv
// fp21_nearest_hit: streaming nearest-hit selector for the intersection stage.
// One candidate distance (unpacked FP21: sign, signed exponent, fraction)
// is accepted per cycle. The block keeps the smallest eligible distance
// under strict less-than ordering and returns it when the packet's last
// beat has been consumed.
//
// Optional build macro: FP21_NEAREST_REJECT_NEG_EN
//   When it is defined, any beat with in_sign=1 (including -0) is treated
//   as a miss, because that geometry lies behind the ray origin.
//
// EXP_W and FRAC_W mirror `exp+1 and `frac+1 from the FP21 core
// definitions, so this file does not depend on that include.

// Strict FP21 less-than: is candidate c < best b?
module fp21_lt #(
  parameter int EXP_W  = 7,
  parameter int FRAC_W = 14
) (
  input  logic                    i_c_sign,
  input  logic signed [EXP_W-1:0] i_c_exp,
  input  logic [FRAC_W-1:0]       i_c_frac,
  input  logic                    i_b_sign,
  input  logic signed [EXP_W-1:0] i_b_exp,
  input  logic [FRAC_W-1:0]       i_b_frac,
  output logic                    o_lt
);
  logic w_exp_lt;
  logic w_exp_eq;
  logic w_frac_lt;
  logic w_frac_eq;
  logic w_mag_lt;
  logic w_mag_eq;

  // Both exponent operands are signed, so this compare is signed.
  assign w_exp_lt  = (i_c_exp < i_b_exp);
  assign w_exp_eq  = (i_c_exp == i_b_exp);
  assign w_frac_lt = (i_c_frac < i_b_frac);
  assign w_frac_eq = (i_c_frac == i_b_frac);
  assign w_mag_lt  = w_exp_lt | (w_exp_eq & w_frac_lt);
  assign w_mag_eq  = w_exp_eq & w_frac_eq;

  // A differing sign decides the order by itself, which puts -0 below +0.
  // Two negative values order in reverse of their magnitudes.
  always_comb begin
    o_lt = 1'b0;
    if (i_c_sign != i_b_sign)
      o_lt = i_c_sign;
    else if (!i_c_sign)
      o_lt = w_mag_lt;
    else
      o_lt = ~w_mag_lt & ~w_mag_eq;
  end
endmodule

module fp21_nearest_hit #(
  parameter int ID_W   = 16,
  parameter int EXP_W  = 7,
  parameter int FRAC_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_hit,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [FRAC_W-1:0]       in_frac,
  input  logic [ID_W-1:0]         in_id,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_hit,
  output logic                    out_sign,
  output logic signed [EXP_W-1:0] out_exp,
  output logic [FRAC_W-1:0]       out_frac,
  output logic [ID_W-1:0]         out_id
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic                      r_have_best;
  logic                      r_best_sign;
  logic signed [EXP_W-1:0]   r_best_exp;
  logic [FRAC_W-1:0]         r_best_frac;
  logic [ID_W-1:0]           r_best_id;

  logic                      w_accept;
  logic                      w_eligible;
  logic                      w_have_eff;
  logic                      w_lt;
  logic                      w_take;
  logic                      w_out_sel;

  assign w_accept = in_valid & in_ready;

`ifdef FP21_NEAREST_REJECT_NEG_EN
  assign w_eligible = in_hit & ~in_sign;
`else
  assign w_eligible = in_hit;
`endif

  // The first beat of a packet must not see the previous packet's best.
  assign w_have_eff = (r_state == S_IDLE) ? 1'b0 : r_have_best;

  fp21_lt #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_lt (
    .i_c_sign (in_sign),
    .i_c_exp  (in_exp),
    .i_c_frac (in_frac),
    .i_b_sign (r_best_sign),
    .i_b_exp  (r_best_exp),
    .i_b_frac (r_best_frac),
    .o_lt     (w_lt)
  );

  // Strict compare: on a tie the earlier beat is kept.
  assign w_take = w_accept & w_eligible & (~w_have_eff | w_lt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (w_accept)
          w_state_nxt = in_last ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = ~rst;
        if (w_accept && in_last)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Best-so-far tracking. These registers do not change in DONE, so the
  // result holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_have_best <= 1'b0;
      r_best_sign <= 1'b0;
      r_best_exp  <= '0;
      r_best_frac <= '0;
      r_best_id   <= '0;
    end else if (w_accept) begin
      r_have_best <= w_have_eff | w_take;
      if (w_take) begin
        r_best_sign <= in_sign;
        r_best_exp  <= in_exp;
        r_best_frac <= in_frac;
        r_best_id   <= in_id;
      end
    end
  end

  // Result fields read zero unless a hit is being presented.
  assign w_out_sel = out_valid & r_have_best;
  assign out_hit   = w_out_sel;
  assign out_sign  = w_out_sel ? r_best_sign : 1'b0;
  assign out_exp   = w_out_sel ? r_best_exp  : '0;
  assign out_frac  = w_out_sel ? r_best_frac : '0;
  assign out_id    = w_out_sel ? r_best_id   : '0;
endmodule

// File: doc/fp21_nearest_hit.md
# fp21_nearest_hit

Streaming nearest-hit selector for the path tracer's intersection stage. Consumes a packet of candidate hit distances (unpacked FP21, one per cycle, each tagged with a primitive ID) and keeps the smallest distance using FP21 strict less-than ordering. On the packet's last beat it presents the winning distance and ID through a valid/ready output. It sits between the ray/primitive intersection units and shading.

## Interface
- `ID_W`, default 16: primitive ID width.
- `clk`, input, 1: clock, all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: candidate beat valid.
- `in_ready`, output, 1: block accepts a beat.
- `in_hit`, input, 1: beat carries a real intersection; 0 means a miss that is counted but never selected.
- `in_sign`, input, 1: candidate distance sign.
- `in_exp`, input, `` `exp``+1: signed candidate exponent. Width comes from `FP21_cores/definitions.vh`.
- `in_frac`, input, `` `frac``+1: candidate fraction, packed or unpacked form.
- `in_id`, input, `ID_W`: primitive ID.
- `in_last`, input, 1: final beat of the packet.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts result.
- `out_hit`, output, 1: at least one candidate was selected.
- `out_sign`, `out_exp`, `out_frac`, `out_id`, outputs, same widths as inputs: nearest distance and its ID.

## Operation
- Beat accepted when `in_valid & in_ready`.
- States:
  - IDLE: no beat of the current packet accepted yet.
  - ACCUM: at least one non-last beat accepted.
  - DONE: result held.
- Transitions:
  - IDLE or ACCUM, accepted beat with `in_last=1`: go to DONE.
  - IDLE, accepted beat with `in_last=0`: go to ACCUM.
  - DONE, `out_valid & out_ready`: go to IDLE.
- `in_ready` is 1 in IDLE and ACCUM, 0 in DONE, and 0 while `rst` is high.
- Best registers: `have_best`, sign, exp, frac, id.
  - The first accepted beat of a packet clears `have_best` before it is evaluated.
- An eligible beat replaces best when `!have_best`, or when candidate < best.
- Less-than ordering:
  - Signs differ: the candidate is less iff `in_sign=1`.
  - Otherwise, magnitude-less means `(exp_c < exp_b)`, or `(exp_c == exp_b) & (frac_c < frac_b)`, with exponents compared as signed.
  - Both positive: the candidate is less iff magnitude-less.
  - Both negative: the candidate is less iff not magnitude-less and not exactly equal.
- Ties are strict: on equal distance the earlier ID is kept. -0 orders below +0.
- DONE outputs:
  - `out_hit = have_best`.
  - If `out_hit=0`, distance and ID outputs are driven to 0.
- Output fields are stable while `out_valid=1` and `out_ready=0`.

## Timing
- Throughput: one beat per cycle in IDLE/ACCUM, with no bubbles between beats.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted. That beat's comparison is already reflected in the outputs.
- `out_valid` falls the cycle after the output handshake; `in_ready` is 1 in that same cycle. The minimum packet period is therefore 2 cycles for a 1-beat packet.
- Reset values: `out_valid=0`, `out_hit=0`, `out_sign=0`, `out_exp=0`, `out_frac=0`, `out_id=0`, state IDLE, `have_best=0`.
- Reset mid-packet or while in DONE discards everything; no result is emitted.
- `in_valid` while in DONE is ignored; the beat is not consumed.

## Configuration
- `FP21_NEAREST_REJECT_NEG_EN`:
  - Defined: beats with `in_sign=1` are treated as misses (geometry behind the ray origin) and are never selected. -0 is also rejected.
  - Undefined: full signed ordering as above, so negative distances can win.

## Test plan
- 3-beat packet: hit distances 4.0, 1.5, 2.0 with IDs 10, 11, 12; last on beat 3 -> `out_hit=1`, distance 1.5, `out_id=11`, `out_valid` one cycle after beat 3.
- Tie: hits at 2.0 with IDs 5 then 6 -> `out_id=5`. Same exponent, smaller fraction (1.25 vs 1.5) -> the 1.25 beat wins.
- All-miss packet of 4 beats (`in_hit=0`) -> `out_hit=1'b0`, all fields 0.
- Hits at -3.0 (ID 1) and 2.0 (ID 2):
  - Macro defined -> ID 2.
  - Macro undefined -> ID 1, distance -3.0.
- Backpressure: hold `out_ready=0` for 5 cycles -> outputs stable, `in_ready=0`, offered beats not consumed. Release -> `in_ready=1` the next cycle.
- Assert `rst` after 2 of 3 beats, then send a new 1-beat packet at 7.0 (ID 9) -> exactly one result: 7.0, ID 9.
